// File: rtl/shift_add_mult_n_pkg.sv
// Shared definitions for the shift-add multiplier family: FSM states, counter
// sizing and the operand magnitude helper used by several arithmetic blocks.
package shift_add_mult_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned ABS_MAX_W = 64;

    // Step counter runs 0..N-1; at least one bit even for tiny N.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n < 32'd3) begin
            w = 32'd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(32'd8);

    // |x| over the low w bits; in signed mode the most negative value maps to
    // 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [ABS_MAX_W-1:0] abs_n(input logic [ABS_MAX_W-1:0] x,
                                                   input int unsigned          w,
                                                   input logic                 sgn);
        logic [ABS_MAX_W-1:0] mask;
        logic [ABS_MAX_W-1:0] r;
        logic                 msb;
        if (w >= ABS_MAX_W) begin
            mask = {ABS_MAX_W{1'b1}};
        end else begin
            mask = (64'd1 << w) - 64'd1;
        end
        msb = ((x >> (w - 32'd1)) & 64'd1) != 64'd0;
        if (sgn && msb) begin
            r = (~x + 64'd1) & mask;
        end else begin
            r = x & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_add_mult_n_datapath.sv
// Datapath of the shift-add multiplier: multiplicand/multiplier shifters,
// product accumulator and final two's-complement sign fix.
module mult_datapath_n
    import shift_add_mult_n_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           fix,
    input  logic           sgn,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           b0,
    output logic           bzero_next,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] a_q, a_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   b_q, b_d;
    logic           neg_q, neg_d;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;

    assign a_mag_s = N'(abs_n(64'(a_in), N, sgn));
    assign b_mag_s = N'(abs_n(64'(b_in), N, sgn));

    // Next-state selection: load new operands, take one shift-add step, or fix the sign.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        neg_d = neg_q;
        if (load) begin
            a_d   = {{N{1'b0}}, a_mag_s};
            b_d   = b_mag_s;
            p_d   = {(2*N){1'b0}};
            neg_d = sgn & (a_in[N-1] ^ b_in[N-1]);
        end else if (step) begin
            if (b_q[0]) begin
                p_d = p_q + a_q;
            end else begin
                p_d = p_q;
            end
            a_d = a_q << 1;
            b_d = b_q >> 1;
        end else if (fix) begin
            if (neg_q) begin
                p_d = ~p_q + {{(2*N-1){1'b0}}, 1'b1};
            end else begin
                p_d = p_q;
            end
        end else begin
            p_d = p_q;
        end
    end

    // Datapath registers; reset clears everything so an aborted run leaves no result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= {(2*N){1'b0}};
            b_q   <= {N{1'b0}};
            p_q   <= {(2*N){1'b0}};
            neg_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            neg_q <= neg_d;
        end
    end

    assign b0         = b_q[0];
    assign bzero_next = (b_q[N-1:1] == {(N-1){1'b0}});
    assign p          = p_q;

endmodule

// File: rtl/shift_add_mult_n.sv
// N-bit sequential shift-add multiplier with optional signed mode, early
// termination and a start/busy/done handshake. Control only; arithmetic lives in the datapath.
module shift_add_mult_n
    import shift_add_mult_n_pkg::*;
#(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   dataA,
    input  logic [N-1:0]   dataB,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = cnt_width(N);

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            done_q;
    logic            busy_q;
    logic            sgn_s;
    logic            load_s;
    logic            step_s;
    logic            fix_s;
    logic            b0_s;
    logic            bzero_next_s;

    generate
        if (SIGNED_EN) begin : g_signed
            assign sgn_s = signed_mode;
        end else begin : g_unsigned
            assign sgn_s = 1'b0;
        end
    endgenerate

    assign load_s = (state_q == IDLE) && start;
    assign step_s = (state_q == CALC);
    assign fix_s  = (state_q == FIN);

    mult_datapath_n #(.N(N)) u_dp (
        .clk        (clk),
        .rst_n      (reset),
        .load       (load_s),
        .step       (step_s),
        .fix        (fix_s),
        .sgn        (sgn_s),
        .a_in       (dataA),
        .b_in       (dataB),
        .b0         (b0_s),
        .bzero_next (bzero_next_s),
        .p          (P)
    );

    // Control FSM with step counter; busy and done are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= {CW{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= CALC;
                        count_q <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
                    // Stop once no multiplier bits remain or all N bits were consumed.
                    if (bzero_next_s || (count_q == CW'(N - 1))) begin
                        state_q <= FIN;
                    end else begin
                        state_q <= CALC;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_add_mult_n.sv
// Self-checking bench for shift_add_mult_n (N=8): directed plan cases plus
// random operands compared against an integer-arithmetic reference.
module tb_shift_add_mult_n;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [N-1:0]   dataA = '0;
    logic [N-1:0]   dataB = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_mult_n #(.N(N), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .dataA       (dataA),
        .dataB       (dataB),
        .busy        (busy),
        .done        (done),
        .P           (P)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer product and number of significant bits of |B|.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output logic [15:0] p, output int s);
        int ia, ib, m;
        ia = sm ? int'($signed(a)) : int'(a);
        ib = sm ? int'($signed(b)) : int'(b);
        p  = 16'(ia * ib);
        m  = (ib < 0) ? -ib : ib;
        s  = 0;
        while ((m >> s) != 0) s++;
        if (s == 0) s = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        while (!done && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input string tag);
        logic [15:0] pexp;
        int          s_exp, lat;
        model(a, b, sm, pexp, s_exp);
        dataA = a; dataB = b; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        wait_done(N + 3, lat);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(s_exp + 1));
        chk({tag, "_p"}, 32'(P), 32'(pexp));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_p_hold"}, 32'(P), 32'(pexp));
    endtask

    initial begin
        int lat;
        #12;
        chk("rst_p", 32'(P), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();

        run_op(8'd15, 8'd13, 1'b0, "u15x13");
        chk("u15x13_val", 32'(P), 32'h00C3);
        run_op(8'd255, 8'd255, 1'b0, "u255x255");
        chk("u255x255_val", 32'(P), 32'hFE01);
        run_op(8'hFD, 8'h05, 1'b1, "sm3x5");
        chk("sm3x5_val", 32'(P), 32'hFFF1);
        run_op(8'h80, 8'h80, 1'b1, "sm128sq");
        chk("sm128sq_val", 32'(P), 32'h4000);
        run_op(8'd200, 8'd0, 1'b0, "u200x0");
        run_op(8'd7, 8'd1, 1'b0, "u7x1");
        chk("u7x1_val", 32'(P), 32'h0007);

        // start re-pulsed with new operands during CALC must be ignored
        dataA = 8'd255; dataB = 8'd200; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dataA = 8'd3; dataB = 8'd3; signed_mode = 1'b1;
        tick();
        start = 1'b0; dataA = 8'd0; dataB = 8'd0;
        wait_done(N + 3, lat);
        chk("ignore_done", 32'(done), 32'd1);
        chk("ignore_p", 32'(P), 32'hC738);
        tick();

        // start held high: the done edge accepts the next operation and clears P
        dataA = 8'd15; dataB = 8'd13; signed_mode = 1'b0; start = 1'b1;
        tick();
        wait_done(N + 3, lat);
        chk("held_done", 32'(done), 32'd1);
        chk("held_p1", 32'(P), 32'h00C3);
        dataA = 8'd9; dataB = 8'd11;
        tick();
        chk("held_restart_busy", 32'(busy), 32'd1);
        chk("held_restart_p", 32'(P), 32'd0);
        chk("held_restart_done", 32'(done), 32'd0);
        start = 1'b0;
        wait_done(N + 3, lat);
        chk("held_p2", 32'(P), 32'd99);
        tick();

        // asynchronous reset mid-CALC
        dataA = 8'd255; dataB = 8'd255; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_p", 32'(P), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        #2 reset = 1'b1;
        tick();
        run_op(8'd6, 8'd7, 1'b0, "u6x7");
        chk("u6x7_val", 32'(P), 32'h002A);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
